// File: rtl/hoplite_pkg.sv
// Shared definitions for the Hoplite injection path: field select codes,
// default field geometry, packet width helper and drain FSM encoding.
package hoplite_pkg;

  localparam logic [3:0] SEL_X      = 4'd0;
  localparam logic [3:0] SEL_Y      = 4'd1;
  localparam logic [3:0] SEL_MCAST  = 4'd2;
  localparam logic [3:0] SEL_DONE   = 4'd3;
  localparam logic [3:0] SEL_RESULT = 4'd4;
  localparam logic [3:0] SEL_MTYPE  = 4'd5;
  localparam logic [3:0] SEL_MX     = 4'd6;
  localparam logic [3:0] SEL_MY     = 4'd7;
  localparam logic [3:0] SEL_ELEM   = 4'd8;
  localparam int         NUM_FIELDS = 9;

  localparam int DEF_COORD_BITS          = 1;
  localparam int DEF_MULTICAST_GROUP_BITS = 1;
  localparam int DEF_MATRIX_TYPE_BITS    = 1;
  localparam int DEF_MATRIX_COORD_BITS   = 8;
  localparam int DEF_MATRIX_ELEMENT_BITS = 32;

  // Bit offsets of each field (LSB) at the default geometry; elem sits at bit 0.
  localparam int DEF_OFF_ELEM   = 0;
  localparam int DEF_OFF_MY     = DEF_OFF_ELEM + DEF_MATRIX_ELEMENT_BITS;
  localparam int DEF_OFF_MX     = DEF_OFF_MY + DEF_MATRIX_COORD_BITS;
  localparam int DEF_OFF_MTYPE  = DEF_OFF_MX + DEF_MATRIX_COORD_BITS;
  localparam int DEF_OFF_RESULT = DEF_OFF_MTYPE + DEF_MATRIX_TYPE_BITS;
  localparam int DEF_OFF_DONE   = DEF_OFF_RESULT + 1;
  localparam int DEF_OFF_MCAST  = DEF_OFF_DONE + 1;
  localparam int DEF_OFF_Y      = DEF_OFF_MCAST + DEF_MULTICAST_GROUP_BITS;
  localparam int DEF_OFF_X      = DEF_OFF_Y + DEF_COORD_BITS;

  function automatic int packet_bits(input int cb, input int mgb, input int mtb,
                                     input int mcb, input int meb);
    return 2*cb + mgb + 2 + mtb + 2*mcb + meb;
  endfunction

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } drain_state_e;

endpackage

// File: rtl/hoplite_pkt_fifo.sv
// Synchronous packet FIFO with registered full/empty and occupancy level.
// A pop on an empty FIFO is ignored, so push+pop when empty never forwards.
module hoplite_pkt_fifo #(
  parameter  int WIDTH = 54,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_o
);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        full_q, full_d, empty_q, empty_d;
  logic                        do_push, do_pop;

  assign do_pop  = pop_i && !empty_q;
  // Full FIFO still takes a push when the head leaves in the same cycle.
  assign do_push = push_i && (!full_q || do_pop);

  always_comb begin
    wptr_d  = wptr_q + AW'(do_push);
    rptr_d  = rptr_q + AW'(do_pop);
    level_d = level_q + LW'(do_push) - LW'(do_pop);
    full_d  = (level_d == LW'(DEPTH));
    empty_d = (level_d == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (do_push) mem_q[wptr_q] <= wdata_i;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign level_o = level_q;

endmodule

// File: rtl/hoplite_tx_controller.sv
// Collects CPU field stores into a staged packet, commits it into a FIFO and
// drains the FIFO into the router injection port with a valid/ready handshake.
module hoplite_tx_controller
  import hoplite_pkg::*;
#(
  parameter  int COORD_BITS           = DEF_COORD_BITS,
  parameter  int MULTICAST_GROUP_BITS = DEF_MULTICAST_GROUP_BITS,
  parameter  int MATRIX_TYPE_BITS     = DEF_MATRIX_TYPE_BITS,
  parameter  int MATRIX_COORD_BITS    = DEF_MATRIX_COORD_BITS,
  parameter  int MATRIX_ELEMENT_BITS  = DEF_MATRIX_ELEMENT_BITS,
  parameter  int FIFO_DEPTH           = 4,
  parameter  int COUNT_BITS           = 16,
  localparam int PACKET_BITS = packet_bits(COORD_BITS, MULTICAST_GROUP_BITS,
                                           MATRIX_TYPE_BITS, MATRIX_COORD_BITS,
                                           MATRIX_ELEMENT_BITS),
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   field_we,
  input  logic [3:0]             field_sel,
  input  logic [31:0]            field_wdata,
  input  logic                   packet_complete,
  output logic                   message_out_ready,
  output logic [PACKET_BITS-1:0] pkt_out,
  output logic                   pkt_out_valid,
  input  logic                   pkt_out_ready,
  output logic [LVL_W-1:0]       fifo_level,
  output logic [COUNT_BITS-1:0]  drop_count,
  output logic [COUNT_BITS-1:0]  malformed_count
);

  logic [COORD_BITS-1:0]           x_q, x_d, y_q, y_d;
  logic [MULTICAST_GROUP_BITS-1:0] mc_q, mc_d;
  logic                            done_q, done_d, res_q, res_d;
  logic [MATRIX_TYPE_BITS-1:0]     mt_q, mt_d;
  logic [MATRIX_COORD_BITS-1:0]    mx_q, mx_d, my_q, my_d;
  logic [MATRIX_ELEMENT_BITS-1:0]  el_q, el_d;
  logic [NUM_FIELDS-1:0]           mask_q, mask_d, wr_bit;
  logic [COUNT_BITS-1:0]           drop_q, drop_d, malf_q, malf_d;
  logic [PACKET_BITS-1:0]          staged, fifo_head, pkt_q, pkt_d;
  drain_state_e                    state_q, state_d;
  logic                            sel_ok, mask_full;
  logic                            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic                            unused_wdata;

  assign unused_wdata = ^field_wdata;
  assign sel_ok       = (field_sel <= SEL_ELEM);
  assign wr_bit       = (field_we && sel_ok) ? (NUM_FIELDS'(1) << field_sel) : '0;
  assign mask_full    = &mask_q;
  assign staged       = {x_q, y_q, mc_q, done_q, res_q, mt_q, mx_q, my_q, el_q};

  // Commit always sees the registered staging state; a same-cycle write lands
  // in the next packet and contributes only its own mask bit.
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    mc_d   = mc_q;
    done_d = done_q;
    res_d  = res_q;
    mt_d   = mt_q;
    mx_d   = mx_q;
    my_d   = my_q;
    el_d   = el_q;
    if (field_we) begin
      unique case (field_sel)
        SEL_X:      x_d    = field_wdata[COORD_BITS-1:0];
        SEL_Y:      y_d    = field_wdata[COORD_BITS-1:0];
        SEL_MCAST:  mc_d   = field_wdata[MULTICAST_GROUP_BITS-1:0];
        SEL_DONE:   done_d = field_wdata[0];
        SEL_RESULT: res_d  = field_wdata[0];
        SEL_MTYPE:  mt_d   = field_wdata[MATRIX_TYPE_BITS-1:0];
        SEL_MX:     mx_d   = field_wdata[MATRIX_COORD_BITS-1:0];
        SEL_MY:     my_d   = field_wdata[MATRIX_COORD_BITS-1:0];
        SEL_ELEM:   el_d   = field_wdata[MATRIX_ELEMENT_BITS-1:0];
        default: ;
      endcase
    end
    mask_d = (packet_complete ? '0 : mask_q) | wr_bit;
  end

  always_comb begin
    fifo_push = 1'b0;
    drop_d    = drop_q;
    malf_d    = malf_q;
    if (packet_complete) begin
      if (!mask_full) begin
        if (malf_q != '1) malf_d = malf_q + COUNT_BITS'(1);
      end else if (fifo_full && !fifo_pop) begin
        if (drop_q != '1) drop_d = drop_q + COUNT_BITS'(1);
      end else begin
        fifo_push = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pkt_d    = pkt_q;
    fifo_pop = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          pkt_d    = fifo_head;
          state_d  = ST_SEND;
        end
      end
      ST_SEND: begin
        if (pkt_out_ready) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            pkt_d    = fifo_head;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      mc_q    <= '0;
      done_q  <= 1'b0;
      res_q   <= 1'b0;
      mt_q    <= '0;
      mx_q    <= '0;
      my_q    <= '0;
      el_q    <= '0;
      mask_q  <= '0;
      drop_q  <= '0;
      malf_q  <= '0;
      pkt_q   <= '0;
      state_q <= ST_IDLE;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      mc_q    <= mc_d;
      done_q  <= done_d;
      res_q   <= res_d;
      mt_q    <= mt_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      el_q    <= el_d;
      mask_q  <= mask_d;
      drop_q  <= drop_d;
      malf_q  <= malf_d;
      pkt_q   <= pkt_d;
      state_q <= state_d;
    end
  end

  hoplite_pkt_fifo #(
    .WIDTH (PACKET_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (staged),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign message_out_ready = !fifo_full;
  assign pkt_out           = pkt_q;
  assign pkt_out_valid     = (state_q == ST_SEND);
  assign drop_count        = drop_q;
  assign malformed_count   = malf_q;

endmodule

// File: tb/tb_hoplite_tx_controller.sv
// Directed bench for hoplite_tx_controller at default parameters.
module tb_hoplite_tx_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        field_we;
  logic [3:0]  field_sel;
  logic [31:0] field_wdata;
  logic        packet_complete;
  logic        message_out_ready;
  logic [53:0] pkt_out;
  logic        pkt_out_valid;
  logic        pkt_out_ready;
  logic [2:0]  fifo_level;
  logic [15:0] drop_count;
  logic [15:0] malformed_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hoplite_tx_controller dut (
    .clk               (clk),
    .reset             (reset),
    .field_we          (field_we),
    .field_sel         (field_sel),
    .field_wdata       (field_wdata),
    .packet_complete   (packet_complete),
    .message_out_ready (message_out_ready),
    .pkt_out           (pkt_out),
    .pkt_out_valid     (pkt_out_valid),
    .pkt_out_ready     (pkt_out_ready),
    .fifo_level        (fifo_level),
    .drop_count        (drop_count),
    .malformed_count   (malformed_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected packet: x=1 y=0 mcast=1 done=0 result=1 mtype=0 mx=05 my=0A elem
  function automatic logic [53:0] pk(input logic [31:0] el);
    return {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h0A, el};
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] s, input logic [31:0] d);
    field_we = 1'b1; field_sel = s; field_wdata = d;
    tick();
    field_we = 1'b0;
  endtask

  task automatic write_common();
    wr(4'd0, 32'd1); wr(4'd1, 32'd0); wr(4'd2, 32'd1); wr(4'd3, 32'd0);
    wr(4'd4, 32'd1); wr(4'd5, 32'd0); wr(4'd6, 32'h05); wr(4'd7, 32'h0A);
  endtask

  task automatic commit();
    packet_complete = 1'b1;
    tick();
    packet_complete = 1'b0;
  endtask

  task automatic send(input logic [31:0] el);
    write_common();
    wr(4'd8, el);
    commit();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; field_we = 1'b0; field_sel = '0; field_wdata = '0;
    packet_complete = 1'b0; pkt_out_ready = 1'b0;
    @(negedge clk); @(negedge clk);
    chk("rst_valid", pkt_out_valid, 0);
    chk("rst_pkt", pkt_out, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_mor", message_out_ready, 1);
    chk("rst_drop", drop_count, 0);
    chk("rst_malf", malformed_count, 0);
    reset = 1'b0;
    tick();

    // Single packet, latency and layout
    pkt_out_ready = 1'b1;
    write_common();
    wr(4'd8, 32'hDEADBEEF);
    commit();
    chk("t1_valid_n1", pkt_out_valid, 0);
    chk("t1_level_n1", fifo_level, 1);
    tick();
    chk("t1_valid_n2", pkt_out_valid, 1);
    chk("t1_pkt", pkt_out, {1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h05, 8'h0A, 32'hDEADBEEF});
    chk("t1_level_n2", fifo_level, 0);
    tick();
    chk("t1_valid_after", pkt_out_valid, 0);

    // Fill with router stalled, overflow, then drain in order
    pkt_out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send(32'h100 + k);
    chk("t2_level4", fifo_level, 3);
    chk("t2_mor4", message_out_ready, 1);
    chk("t2_head", pkt_out, pk(32'h101));
    send(32'h105);
    chk("t2_level5", fifo_level, 4);
    chk("t2_mor5", message_out_ready, 0);
    send(32'h106);
    chk("t2_drop", drop_count, 1);
    chk("t2_level6", fifo_level, 4);
    pkt_out_ready = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      chk("t2_drain_v", pkt_out_valid, 1);
      chk("t2_drain_pkt", pkt_out, pk(32'h100 + k));
      tick();
    end
    chk("t2_done_v", pkt_out_valid, 0);
    chk("t2_done_lvl", fifo_level, 0);
    chk("t2_done_mor", message_out_ready, 1);

    // Missing elem plus an ignored select code
    write_common();
    wr(4'd9, 32'hFFFF_FFFF);
    commit();
    chk("t3_malf", malformed_count, 1);
    chk("t3_level", fifo_level, 0);
    tick();
    chk("t3_valid", pkt_out_valid, 0);
    chk("t3_drop", drop_count, 1);

    // Commit into a full FIFO while the router pops
    pkt_out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) send(32'h200 + k);
    chk("t4_full_lvl", fifo_level, 4);
    write_common();
    wr(4'd8, 32'h206);
    pkt_out_ready = 1'b1;
    commit();
    chk("t4_level", fifo_level, 4);
    chk("t4_drop", drop_count, 1);
    for (int k = 2; k <= 6; k++) begin
      chk("t4_drain_v", pkt_out_valid, 1);
      chk("t4_drain_pkt", pkt_out, pk(32'h200 + k));
      tick();
    end
    chk("t4_done_v", pkt_out_valid, 0);

    // Write in the same cycle as a commit: old elem goes out, new bit only
    write_common();
    wr(4'd8, 32'd3);
    field_we = 1'b1; field_sel = 4'd8; field_wdata = 32'd7;
    commit();
    field_we = 1'b0;
    tick();
    chk("t5_valid", pkt_out_valid, 1);
    chk("t5_pkt", pkt_out, pk(32'd3));
    commit();
    chk("t5_only_bit8", malformed_count, 2);
    write_common();
    wr(4'd8, 32'd3);
    field_we = 1'b1; field_sel = 4'd8; field_wdata = 32'd7;
    commit();
    field_we = 1'b0;
    tick(); tick();
    write_common();
    commit();
    tick();
    chk("t5_next_v", pkt_out_valid, 1);
    chk("t5_next_pkt", pkt_out, pk(32'd7));
    chk("t5_malf_keep", malformed_count, 2);
    tick();

    // Async reset while sending with packets queued
    pkt_out_ready = 1'b0;
    for (int k = 1; k <= 3; k++) send(32'h300 + k);
    chk("t6_pre_v", pkt_out_valid, 1);
    chk("t6_pre_lvl", fifo_level, 2);
    #2 reset = 1'b1;
    #1;
    chk("t6_valid", pkt_out_valid, 0);
    chk("t6_level", fifo_level, 0);
    chk("t6_drop", drop_count, 0);
    chk("t6_malf", malformed_count, 0);
    chk("t6_mor", message_out_ready, 1);
    chk("t6_pkt", pkt_out, 0);
    @(negedge clk);
    reset = 1'b0;
    tick(); tick();
    chk("t6_post_v", pkt_out_valid, 0);
    chk("t6_post_lvl", fifo_level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hoplite_tx_controller.md
Name: hoplite_tx_controller

Overview:
Sequences packet injection from a node's processor into its Hoplite router. Field stores from the memory-mapped IO decoder are collected into a staging register; a packet-complete strobe commits the packet into a small FIFO. A drain FSM presents FIFO packets to the router injection port with a valid/ready handshake. It also exports a CPU-pollable ready flag and error counters, and replaces the direct per-field register outputs of the node system.

Parameters:
COORD_BITS, 1, router x/y coordinate width
MULTICAST_GROUP_BITS, 1, multicast group width
MATRIX_TYPE_BITS, 1, matrix type field width
MATRIX_COORD_BITS, 8, matrix x/y coordinate width
MATRIX_ELEMENT_BITS, 32, matrix element width
FIFO_DEPTH, 4, packet FIFO entries; power of two, at least 2
COUNT_BITS, 16, width of drop and malformed counters
PACKET_BITS, derived, 2*COORD_BITS+MULTICAST_GROUP_BITS+2+MATRIX_TYPE_BITS+2*MATRIX_COORD_BITS+MATRIX_ELEMENT_BITS (54 at defaults)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
field_we  input  1  field write strobe, one cycle per CPU store
field_sel  input  4  field select: 0 x, 1 y, 2 mcast, 3 done, 4 result, 5 mtype, 6 mx, 7 my, 8 elem; codes 9-15 are ignored
field_wdata  input  32  field value; only LSBs up to the field width are used
packet_complete  input  1  commit staged packet
message_out_ready  output  1  FIFO not full; CPU polls this before committing
pkt_out  output  PACKET_BITS  packet to router
pkt_out_valid  output  1  pkt_out holds a valid packet
pkt_out_ready  input  1  router accepts the injection this cycle
fifo_level  output  log2(FIFO_DEPTH)+1  current FIFO occupancy
drop_count  output  COUNT_BITS  commits lost because the FIFO was full
malformed_count  output  COUNT_BITS  commits rejected because fields were missing

Behaviour:
- Reset (async assert, sync deassert by the caller):
  - Staging register, field mask, FIFO pointers and counters all go to 0.
  - pkt_out_valid=0, pkt_out=0, fifo_level=0, message_out_ready=1.
- Staging:
  - A write with a valid field_sel updates that field and sets its bit in a 9-bit field mask.
  - A rewrite before commit overwrites the field; the last write wins.
- Commit (packet_complete=1):
  - Mask all-ones and FIFO has space: push the staged packet, then clear the mask. Staged values persist.
  - Mask incomplete: no push, malformed_count+1, mask cleared.
  - FIFO full with no pop in the same cycle: no push, drop_count+1, mask cleared.
  - FIFO full with a pop in the same cycle: the push succeeds.
- field_we and packet_complete in the same cycle: the commit uses the pre-write staged value and mask. The write then applies to the next packet and sets only its own mask bit.
- Both counters saturate at all-ones.
- Packet layout, MSB to LSB: x, y, mcast, done, result, mtype, mx, my, elem.
- message_out_ready = (fifo_level != FIFO_DEPTH), combinational from registered state.
- Drain FSM, output register plus state:
  - IDLE: pkt_out_valid=0. If the FIFO is non-empty, pop the head into pkt_out and go to SEND.
  - Latency: commit at cycle N gives pkt_out_valid=1 at N+2 when the controller is idle (N+1 push visible, N+2 load).
  - SEND: pkt_out_valid=1. pkt_out and pkt_out_valid must stay stable until pkt_out_ready=1.
  - On accept with the FIFO non-empty, load the next head the same cycle and stay in SEND, giving back-to-back injection at one packet per cycle.
  - On accept with the FIFO empty, go to IDLE.
- pkt_out_ready while in IDLE is ignored.
- fifo_level counts FIFO entries only, excluding the packet held in pkt_out. Pointers wrap modulo FIFO_DEPTH.
- Reset mid-SEND drops all packets. No partial state survives reset.

Decomposition:
- Package hoplite_pkg holds:
  - field_sel code constants.
  - Packet field width and offset localparams.
  - PACKET_BITS function.
  - Drain FSM state encoding (IDLE=0, SEND=1).
- One sub-module, hoplite_pkt_fifo: synchronous FIFO, registered full/empty, level output, simultaneous push/pop legal when full or empty. Simultaneous push and pop when empty must not forward in the same cycle.

Test Plan:
- Write all 9 fields (x=1, y=0, mcast=1, done=0, result=1, mtype=0, mx=8'h05, my=8'h0A, elem=32'hDEADBEEF), then commit with pkt_out_ready=1. Required: pkt_out_valid rises 2 cycles after commit, layout matches the packing order, fifo_level returns to 0.
- Hold pkt_out_ready=0 and commit 5 full packets with FIFO_DEPTH=4. Required: after 4 commits fifo_level=3 (one packet in pkt_out); message_out_ready=0 after commit 5; a sixth commit gives drop_count=1; releasing ready drains 5 packets in order, back-to-back.
- Write 8 fields (omit elem), then commit. Required: malformed_count=1, no push, pkt_out_valid stays 0.
- Full FIFO with the router accepting: a commit in the same cycle as a pop. Required: the push succeeds, drop_count unchanged, fifo_level unchanged.
- field_we(sel=8, elem=7) in the same cycle as a commit of a complete packet with elem=3. Required: the sent packet has elem=3 and the mask holds only bit 8 afterward.
- Assert reset while in SEND with 2 packets queued. Required: pkt_out_valid=0 immediately (async), fifo_level=0, counters 0, message_out_ready=1.
